wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage pipeline. It sits directly downstream of the MEM/WB pipeline register and consumes its `wr_*` outputs. It selects and extends the value written to the general register file and owns the architectural HI/LO registers. It also provides same-cycle HI/LO bypass values to EX and keeps a free-running commit counter.

## Interface
- `W_CNT`, default 32: commit counter width.
- `clk`  in  1: pipeline clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `wr_dout`  in  32: load data from data memory.
- `wr_result`  in  32: ALU result; for loads, the byte address.
- `wr_HL`  in  32: HI or LO value captured in EX for mfhi/mflo.
- `wr_busA_mux2`  in  32: rs operand, the source for mthi/mtlo.
- `wr_mult`  in  64: multiplier/divider product, {hi, lo}.
- `wr_rw`  in  5: destination register number.
- `wr_regWr`  in  1: register-file write request.
- `wr_multWr`  in  1: write `wr_mult` into {HI, LO}.
- `wr_Highin`  in  1: mthi.
- `wr_Lowin`  in  1: mtlo.
- `wr_memtoreg`  in  2: write-data select.
- `wr_op`  in  6: primary opcode.
- `rf_we`  out  1: register-file write enable.
- `rf_waddr`  out  5: register-file write address.
- `rf_wdata`  out  32: register-file write data.
- `hi_q`, `lo_q`  out  32 each: architectural HI and LO.
- `hi_fwd`, `lo_fwd`  out  32 each: the values HI and LO will hold after this edge (bypass).
- `commit_cnt`  out  `W_CNT`: count of committing instructions.

## Operation
- **Register-file write enable:** `rf_we = wr_regWr & (wr_rw != 0)`, so writes to r0 are always suppressed. `rf_waddr = wr_rw`.
- **Write-data select, `wr_memtoreg`:**
  - 00: `wr_result`.
  - 01: extended load data.
  - 10: `wr_HL`.
  - 11: reserved; drives 0.
- **Load extension:** keyed on `wr_op`, with byte lane `a = wr_result[1:0]`, little-endian (lane 0 = `wr_dout[7:0]`).
  - lb 0x20: sign-extend the byte at lane a.
  - lbu 0x24: zero-extend the byte at lane a.
  - lh 0x21: sign-extend the halfword at `a[1]`.
  - lhu 0x25: zero-extend the halfword at `a[1]`.
  - lw 0x23 and any other opcode: `wr_dout` unchanged.
  - Misalignment is not checked: `a[0]` is ignored for halfwords, `a[1:0]` for words.
- **HI/LO update priority:**
  - `wr_multWr` = 1: HI ← `wr_mult[63:32]`, LO ← `wr_mult[31:0]`. `wr_Highin` and `wr_Lowin` are ignored that cycle.
  - Otherwise `wr_Highin` = 1: HI ← `wr_busA_mux2`.
  - Otherwise `wr_Lowin` = 1: LO ← `wr_busA_mux2`.
  - `wr_Highin` and `wr_Lowin` together: both HI and LO take `wr_busA_mux2`.
  - No request: HI and LO hold.
- **Bypass:** `hi_fwd`/`lo_fwd` are the combinational next-state values of HI/LO. When nothing writes, they equal `hi_q`/`lo_q`.
- **Commit counter:** `commit_cnt` increments by 1 on each edge where `rf_we | wr_multWr | wr_Highin | wr_Lowin`. It wraps modulo 2^`W_CNT` and never saturates.

## Timing
- `rf_we`, `rf_waddr` and `rf_wdata` are combinational from the `wr_*` inputs, with zero latency. The register file samples them on the same rising edge that ends the WB cycle.
- HI/LO are updated on the rising edge and visible on `hi_q`/`lo_q` one cycle after the write request.
- `hi_fwd`/`lo_fwd` are valid in the same cycle as the request. EX uses them for an mfhi/mflo directly behind a mult/mthi.
- **Reset:** on `rst_n` = 0, immediately and asynchronously, `hi_q` = `lo_q` = 0 and `commit_cnt` = 0. `rf_*` and `*_fwd` follow the inputs and the reset state. A request present while reset is asserted is lost. After `rst_n` deasserts, the first rising edge performs a normal update.
- No handshake and no stall input: every cycle is a WB cycle. A bubble is all enables = 0.

## Structure
- Package `pipe_pkg` holds:
  - opcode constants `OP_LB`, `OP_LH`, `OP_LW`, `OP_LBU`, `OP_LHU`;
  - memtoreg encodings `M2R_ALU`, `M2R_MEM`, `M2R_HL`, `M2R_RSVD`.
- Sub-module `load_ext` (combinational) takes `wr_op`, `wr_dout` and the address LSBs and produces the extended 32-bit value.
- `wb_stage` holds the write-data mux, the HI/LO registers with priority logic, the bypass and the counter.

## Test plan
- **Load extension:** `wr_dout`=0x80FF7F01, memtoreg=01, rw=5, regWr=1.
  - lb, a=3 → `rf_wdata`=0xFFFFFF80.
  - lbu, a=1 → 0x0000007F.
  - lh, a=2 → 0xFFFF80FF.
  - lhu, a=0 → 0x00007F01.
  - lw → 0x80FF7F01.
- **r0 suppression:** rw=0, regWr=1 → `rf_we`=0 and `commit_cnt` unchanged. With rw=31 → `rf_we`=1 and count +1.
- **mult then mfhi:**
  - multWr with `wr_mult`=0x12345678_9ABCDEF0 → `hi_fwd`=0x12345678 that cycle; `hi_q`/`lo_q` = 0x12345678/0x9ABCDEF0 the next cycle.
  - memtoreg=10 with `wr_HL`=`hi_q` → `rf_wdata`=0x12345678.
- **Priority:** multWr=1 with Highin=1 and busA=0xDEADBEEF → HI takes `wr_mult[63:32]`. Next, Highin=1 and Lowin=1 → HI = LO = 0xDEADBEEF.
- **Reset mid-operation:** assert `rst_n`=0 between edges while HI=0xDEADBEEF → `hi_q`=0 without waiting for a clock edge. A pending multWr is not applied.
- **Counter wrap:** with `W_CNT`=4, 17 committing cycles → `commit_cnt`=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared opcodes and write-back select encodings for the pipeline
package pipe_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  typedef enum logic [1:0] {
    M2R_ALU  = 2'b00,
    M2R_MEM  = 2'b01,
    M2R_HL   = 2'b10,
    M2R_RSVD = 2'b11
  } m2r_e;
endpackage

// File: rtl/load_ext.sv
// load_ext: picks the addressed byte/halfword of a load word and extends it
module load_ext
  import pipe_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] dout,
  input  logic [1:0]  addr,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane select is little-endian; misaligned low bits are simply ignored
  always_comb begin
    b = addr[1] ? (addr[0] ? dout[31:24] : dout[23:16]) : (addr[0] ? dout[15:8] : dout[7:0]);
    h = addr[1] ? dout[31:16] : dout[15:0];
    data = op == OP_LB  ? {{24{b[7]}}, b} :
           op == OP_LBU ? {24'b0, b} :
           op == OP_LH  ? {{16{h[15]}}, h} :
           op == OP_LHU ? {16'b0, h} : dout;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back data select, architectural HI/LO with bypass, commit counter
module wb_stage
  import pipe_pkg::*;
#(
  parameter int W_CNT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      wr_dout,
  input  logic [31:0]      wr_result,
  input  logic [31:0]      wr_HL,
  input  logic [31:0]      wr_busA_mux2,
  input  logic [63:0]      wr_mult,
  input  logic [4:0]       wr_rw,
  input  logic             wr_regWr,
  input  logic             wr_multWr,
  input  logic             wr_Highin,
  input  logic             wr_Lowin,
  input  logic [1:0]       wr_memtoreg,
  input  logic [5:0]       wr_op,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      hi_q,
  output logic [31:0]      lo_q,
  output logic [31:0]      hi_fwd,
  output logic [31:0]      lo_fwd,
  output logic [W_CNT-1:0] commit_cnt
);
  logic [31:0] ld_data;
  logic        commit;
  m2r_e        sel;

  load_ext u_load_ext (
    .op  (wr_op),
    .dout(wr_dout),
    .addr(wr_result[1:0]),
    .data(ld_data)
  );

  // register-file write port and HI/LO next-state; a product write outranks mthi/mtlo
  always_comb begin
    sel      = m2r_e'(wr_memtoreg);
    rf_we    = wr_regWr & (wr_rw != 5'd0);
    rf_waddr = wr_rw;
    rf_wdata = sel == M2R_ALU ? wr_result :
               sel == M2R_MEM ? ld_data :
               sel == M2R_HL  ? wr_HL : 32'd0;
    hi_fwd   = wr_multWr ? wr_mult[63:32] : wr_Highin ? wr_busA_mux2 : hi_q;
    lo_fwd   = wr_multWr ? wr_mult[31:0]  : wr_Lowin  ? wr_busA_mux2 : lo_q;
    commit   = rf_we | wr_multWr | wr_Highin | wr_Lowin;
  end

  // architectural HI/LO and the wrapping commit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '0;
      lo_q       <= '0;
      commit_cnt <= '0;
    end else begin
      hi_q       <= hi_fwd;
      lo_q       <= lo_fwd;
      commit_cnt <= commit_cnt + W_CNT'(commit);
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and random checks of wb_stage against a behavioural model
module tb_wb_stage;
  localparam int W = 4;
  logic clk = 0, rst_n = 0;
  logic [31:0] wr_dout = 0, wr_result = 0, wr_HL = 0, wr_busA_mux2 = 0;
  logic [63:0] wr_mult = 0;
  logic [4:0]  wr_rw = 0;
  logic        wr_regWr = 0, wr_multWr = 0, wr_Highin = 0, wr_Lowin = 0;
  logic [1:0]  wr_memtoreg = 0;
  logic [5:0]  wr_op = 0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_q, lo_q, hi_fwd, lo_fwd;
  logic [W-1:0] commit_cnt;
  int errors = 0, checks = 0;
  logic [31:0] hi_m = 0, lo_m = 0;
  int cnt_m = 0;

  wb_stage #(.W_CNT(W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_dout(wr_dout), .wr_result(wr_result), .wr_HL(wr_HL),
    .wr_busA_mux2(wr_busA_mux2), .wr_mult(wr_mult), .wr_rw(wr_rw), .wr_regWr(wr_regWr),
    .wr_multWr(wr_multWr), .wr_Highin(wr_Highin), .wr_Lowin(wr_Lowin),
    .wr_memtoreg(wr_memtoreg), .wr_op(wr_op), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .hi_q(hi_q), .lo_q(lo_q), .hi_fwd(hi_fwd), .lo_fwd(lo_fwd),
    .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_ld(input int op, input logic [31:0] d, input int a);
    int bv, hv;
    bv = int'((d >> (8 * a)) & 32'hFF);
    hv = int'((d >> (16 * (a / 2))) & 32'hFFFF);
    case (op)
      'h20: return 32'(bv > 127 ? bv - 256 : bv);
      'h24: return 32'(bv);
      'h21: return 32'(hv > 32767 ? hv - 65536 : hv);
      'h25: return 32'(hv);
      default: return d;
    endcase
  endfunction

  task automatic cycle();
    logic ewe;
    logic [31:0] ewd, eh, el;
    ewe = wr_regWr && wr_rw != 0;
    ewd = wr_memtoreg == 0 ? wr_result :
          wr_memtoreg == 1 ? ref_ld(int'(wr_op), wr_dout, int'(wr_result % 4)) :
          wr_memtoreg == 2 ? wr_HL : 32'd0;
    eh = hi_m;
    el = lo_m;
    if (wr_Highin) eh = wr_busA_mux2;
    if (wr_Lowin) el = wr_busA_mux2;
    if (wr_multWr) begin
      eh = wr_mult[63:32];
      el = wr_mult[31:0];
    end
    #1;
    chk("rf_we", 64'(rf_we), 64'(ewe));
    chk("rf_waddr", 64'(rf_waddr), 64'(wr_rw));
    chk("rf_wdata", 64'(rf_wdata), 64'(ewd));
    chk("hi_fwd", 64'(hi_fwd), 64'(eh));
    chk("lo_fwd", 64'(lo_fwd), 64'(el));
    @(posedge clk);
    #1;
    if (rst_n) begin
      hi_m = eh;
      lo_m = el;
      if (ewe || wr_multWr || wr_Highin || wr_Lowin) cnt_m = (cnt_m + 1) % (1 << W);
    end
    chk("hi_q", 64'(hi_q), 64'(hi_m));
    chk("lo_q", 64'(lo_q), 64'(lo_m));
    chk("commit_cnt", 64'(commit_cnt), 64'(cnt_m));
  endtask

  task automatic idle();
    wr_regWr = 0; wr_multWr = 0; wr_Highin = 0; wr_Lowin = 0; wr_memtoreg = 0;
  endtask

  initial begin
    int c0;
    #2;
    chk("reset_hi", 64'(hi_q), 64'd0);
    chk("reset_lo", 64'(lo_q), 64'd0);
    chk("reset_cnt", 64'(commit_cnt), 64'd0);
    #10 rst_n = 1;
    // load extension
    wr_dout = 32'h80FF7F01; wr_memtoreg = 1; wr_rw = 5; wr_regWr = 1;
    wr_op = 6'h20; wr_result = 3; cycle(); chk("lb_a3", 64'(rf_wdata), 64'hFFFFFF80);
    wr_op = 6'h24; wr_result = 1; cycle(); chk("lbu_a1", 64'(rf_wdata), 64'h0000007F);
    wr_op = 6'h21; wr_result = 2; cycle(); chk("lh_a2", 64'(rf_wdata), 64'hFFFF80FF);
    wr_op = 6'h25; wr_result = 0; cycle(); chk("lhu_a0", 64'(rf_wdata), 64'h00007F01);
    wr_op = 6'h23; wr_result = 2; cycle(); chk("lw", 64'(rf_wdata), 64'h80FF7F01);
    // r0 suppression
    c0 = cnt_m;
    wr_rw = 0; wr_memtoreg = 0; cycle(); chk("r0_cnt", 64'(commit_cnt), 64'(c0));
    wr_rw = 31; cycle(); chk("r31_cnt", 64'(commit_cnt), 64'((c0 + 1) % 16));
    // mult then mfhi
    idle(); wr_multWr = 1; wr_mult = 64'h12345678_9ABCDEF0;
    #1 chk("mult_hi_fwd", 64'(hi_fwd), 64'h12345678);
    cycle();
    chk("mult_hi_q", 64'(hi_q), 64'h12345678);
    chk("mult_lo_q", 64'(lo_q), 64'h9ABCDEF0);
    idle(); wr_memtoreg = 2; wr_HL = 32'h12345678; wr_regWr = 1; wr_rw = 3;
    cycle(); chk("mfhi", 64'(rf_wdata), 64'h12345678);
    // priority
    idle(); wr_multWr = 1; wr_Highin = 1; wr_busA_mux2 = 32'hDEADBEEF; wr_mult = 64'hCAFEF00D_0BADC0DE;
    cycle(); chk("prio_hi", 64'(hi_q), 64'hCAFEF00D);
    idle(); wr_Highin = 1; wr_Lowin = 1;
    cycle(); chk("both_hi", 64'(hi_q), 64'hDEADBEEF); chk("both_lo", 64'(lo_q), 64'hDEADBEEF);
    // asynchronous reset with a pending product write
    idle(); wr_multWr = 1; wr_mult = 64'h11111111_22222222;
    #3 rst_n = 0;
    #1 chk("arst_hi", 64'(hi_q), 64'd0); chk("arst_lo", 64'(lo_q), 64'd0); chk("arst_cnt", 64'(commit_cnt), 64'd0);
    hi_m = 0; lo_m = 0; cnt_m = 0;
    @(posedge clk); #1 chk("rst_hold_hi", 64'(hi_q), 64'd0);
    idle(); #3 rst_n = 1;
    // counter wrap: 17 commits from zero
    wr_regWr = 1; wr_rw = 31;
    for (int i = 0; i < 17; i++) cycle();
    chk("wrap", 64'(commit_cnt), 64'd1);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = int'($urandom_range(0, 6));
      wr_op = sel == 0 ? 6'h20 : sel == 1 ? 6'h21 : sel == 2 ? 6'h23 : sel == 3 ? 6'h24 :
              sel == 4 ? 6'h25 : 6'($urandom);
      wr_dout = $urandom; wr_result = $urandom; wr_HL = $urandom; wr_busA_mux2 = $urandom;
      wr_mult = {$urandom, $urandom}; wr_rw = 5'($urandom); wr_regWr = 1'($urandom);
      wr_multWr = $urandom_range(0, 3) == 0; wr_Highin = 1'($urandom); wr_Lowin = 1'($urandom);
      wr_memtoreg = 2'($urandom);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
